// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM encoding and mux selects.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STEAL = 2'd2
  } arbState_e;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_EXT = 1'b1;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/dmem_port_arbiter_ext_req_hold.sv
// Single-entry holding register for host requests, plus the ack pulse and
// registered read-data return.
module dmem_port_arbiter_ext_req_hold #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          extReq,
  input  logic          extWe,
  input  logic [AW-1:0] extAdr,
  input  logic [DW-1:0] extWdata,
  input  logic          service,
  input  logic [DW-1:0] memRdata,
  output logic          holdValid,
  output logic          holdWe,
  output logic [AW-1:0] holdAdr,
  output logic [DW-1:0] holdWdata,
  output logic          extReady,
  output logic          extAck,
  output logic [DW-1:0] extRdata
);

  assign extReady = !holdValid;

  // service only happens while holdValid, acceptance only while !holdValid,
  // so the two branches below are mutually exclusive
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      holdValid <= 1'b0;
      holdWe    <= 1'b0;
      holdAdr   <= '0;
      holdWdata <= '0;
      extAck    <= 1'b0;
      extRdata  <= '0;
    end else begin
      extAck <= 1'b0;
      if (service) begin
        holdValid <= 1'b0;
        extAck    <= 1'b1;
        extRdata  <= memRdata;
      end else if (extReq && extReady) begin
        holdValid <= 1'b1;
        holdWe    <= extWe;
        holdAdr   <= extAdr;
        holdWdata <= extWdata;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the CPU load/store path and the host port:
// boot sequencing, idle-slot host service and forced one-cycle steal on starvation.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          boot_done,
  input  logic          ext_req,
  output logic          ext_ready,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_adr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  input  logic          cpu_mem_en,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_run,
  output logic          cpu_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  arbState_e         state;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNext;
  logic              sel;
  logic              cpuOwns;
  logic              service;
  logic              accept;

  logic              holdValid;
  logic              holdWe;
  logic [AW-1:0]     holdAdr;
  logic [DW-1:0]     holdWdata;

  dmem_port_arbiter_ext_req_hold #(.AW(AW), .DW(DW)) uHold (
    .clk       (clk),
    .rstN      (reset),
    .extReq    (ext_req),
    .extWe     (ext_we),
    .extAdr    (ext_adr),
    .extWdata  (ext_wdata),
    .service   (service),
    .memRdata  (mem_rdata),
    .holdValid (holdValid),
    .holdWe    (holdWe),
    .holdAdr   (holdAdr),
    .holdWdata (holdWdata),
    .extReady  (ext_ready),
    .extAck    (ext_ack),
    .extRdata  (ext_rdata)
  );

  assign accept   = ext_req && ext_ready;
  assign waitNext = (waitCnt == '1) ? waitCnt : waitCnt + 1'b1;

  always_comb begin
    sel = SEL_CPU;
    if (holdValid) begin
      case (state)
        BOOT, STEAL: sel = SEL_EXT;
        RUN:         if (!cpu_mem_en) sel = SEL_EXT;
        default:     sel = SEL_CPU;
      endcase
    end
  end

  assign service = (sel == SEL_EXT);
  assign cpuOwns = (state == RUN) && (sel == SEL_CPU);

  // outside RUN the CPU never reaches the port; an idle BOOT cycle drives zeros
  always_comb begin
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (service) begin
      mem_we    = holdWe;
      mem_adr   = holdAdr;
      mem_wdata = holdWdata;
    end else if (cpuOwns) begin
      mem_we    = cpu_mem_en && cpu_we;
      mem_adr   = cpu_adr;
      mem_wdata = cpu_wdata;
    end
  end

  assign cpu_rdata = cpuOwns ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BOOT;
      waitCnt   <= '0;
      cpu_run   <= 1'b0;
      cpu_stall <= 1'b1;
    end else begin
      case (state)
        BOOT: begin
          waitCnt <= '0;
          // a request accepted this edge must drain before the CPU is released
          if (boot_done && !holdValid && !accept) begin
            state     <= RUN;
            cpu_run   <= 1'b1;
            cpu_stall <= 1'b0;
          end
        end
        RUN: begin
          if (service) begin
            waitCnt <= '0;
          end else if (holdValid) begin
            waitCnt <= waitNext;
            if (waitNext >= MAX_WAIT_C) begin
              state     <= STEAL;
              cpu_stall <= 1'b1;
            end
          end
        end
        STEAL: begin
          waitCnt   <= '0;
          state     <= RUN;
          cpu_stall <= 1'b0;
        end
        default: begin
          state     <= BOOT;
          waitCnt   <= '0;
          cpu_run   <= 1'b0;
          cpu_stall <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed memory model.
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          boot_done = 1'b0;
  logic          ext_req = 1'b0;
  logic          ext_ready;
  logic          ext_we = 1'b0;
  logic [AW-1:0] ext_adr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          ext_ack;
  logic [DW-1:0] ext_rdata;
  logic          cpu_mem_en = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_run;
  logic          cpu_stall;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:63];
  logic          memInit = 1'b0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_adr[5:0]];

  // contents start as 0xA000_00ii so read data is predictable
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      memInit <= 1'b1;
    end else if (mem_we) begin
      mem[mem_adr[5:0]] <= mem_wdata;
    end
  end

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset), .boot_done(boot_done),
    .ext_req(ext_req), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_adr(ext_adr), .ext_wdata(ext_wdata), .ext_ack(ext_ack),
    .ext_rdata(ext_rdata), .cpu_mem_en(cpu_mem_en), .cpu_we(cpu_we),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_run(cpu_run), .cpu_stall(cpu_stall), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", ext_ack); end
    checks++; if (ext_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", ext_rdata); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL rst_run got %b want 0", cpu_run); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got %b want 1", cpu_stall); end
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ext_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
    checks++; if (mem_adr !== 32'h0) begin errors++; $display("FAIL rst_adr got %h want 0", mem_adr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h want 0", cpu_rdata); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_boot_preload();
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b1; ext_adr = 32'h28; ext_wdata = 32'h10;
    #1;
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL pre_ready got %b want 1", ext_ready); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL pre_run got %b want 0", cpu_run); end
    @(negedge clk); ext_req = 1'b0; #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL pre_svc_we got %b want 1", mem_we); end
    checks++; if (mem_adr !== 32'h28) begin errors++; $display("FAIL pre_svc_adr got %h want 28", mem_adr); end
    checks++; if (mem_wdata !== 32'h10) begin errors++; $display("FAIL pre_svc_wdata got %h want 10", mem_wdata); end
    checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL pre_svc_ready got %b want 0", ext_ready); end
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL pre_svc_ack got %b want 0", ext_ack); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL pre_svc_stall got %b want 1", cpu_stall); end
    @(negedge clk); #1;
    checks++; if (ext_ack !== 1'b1) begin errors++; $display("FAIL pre_ack got %b want 1", ext_ack); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL pre_ack_we got %b want 0", mem_we); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL pre_ack_stall got %b want 1", cpu_stall); end
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b0; ext_adr = 32'h28;
    #1;
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL pre_ack_pulse got %b want 0", ext_ack); end
    @(negedge clk); ext_req = 1'b0; #1;
    checks++; if (mem_adr !== 32'h28) begin errors++; $display("FAIL pre_rd_adr got %h want 28", mem_adr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL pre_rd_we got %b want 0", mem_we); end
    @(negedge clk); #1;
    checks++; if (ext_ack !== 1'b1) begin errors++; $display("FAIL pre_rd_ack got %b want 1", ext_ack); end
    checks++; if (ext_rdata !== 32'h10) begin errors++; $display("FAIL pre_rd_data got %h want 10", ext_rdata); end
  endtask

  task automatic test_boot_drain();
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b1; ext_adr = 32'h30; ext_wdata = 32'h55; boot_done = 1'b1;
    #1;
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL drain_acc_run got %b want 0", cpu_run); end
    @(negedge clk); ext_req = 1'b0; #1;
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL drain_svc_run got %b want 0", cpu_run); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL drain_svc_stall got %b want 1", cpu_stall); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL drain_svc_we got %b want 1", mem_we); end
    checks++; if (mem_adr !== 32'h30) begin errors++; $display("FAIL drain_svc_adr got %h want 30", mem_adr); end
    @(negedge clk); #1;
    checks++; if (ext_ack !== 1'b1) begin errors++; $display("FAIL drain_ack got %b want 1", ext_ack); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL drain_ack_run got %b want 0", cpu_run); end
    @(negedge clk); #1;
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL drain_run got %b want 1", cpu_run); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL drain_stall got %b want 0", cpu_stall); end
    checks++; if (mem[6'h30] !== 32'h55) begin errors++; $display("FAIL drain_mem got %h want 55", mem[6'h30]); end
  endtask

  task automatic test_idle_slot();
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b0; ext_adr = 32'h21; cpu_mem_en = 1'b0;
    #1;
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", ext_ready); end
    @(negedge clk); ext_req = 1'b0; #1;
    checks++; if (mem_adr !== 32'h21) begin errors++; $display("FAIL idle_adr got %h want 21", mem_adr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b want 0", mem_we); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b want 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL idle_cpu_rdata got %h want 0", cpu_rdata); end
    @(negedge clk); #1;
    checks++; if (ext_ack !== 1'b1) begin errors++; $display("FAIL idle_ack got %b want 1", ext_ack); end
    checks++; if (ext_rdata !== 32'hA000_0021) begin errors++; $display("FAIL idle_rdata got %h want a0000021", ext_rdata); end
  endtask

  task automatic test_cpu_priority();
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b1; ext_adr = 32'h03; ext_wdata = 32'h77;
    @(negedge clk);
    ext_req = 1'b0;
    cpu_mem_en = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h26; cpu_wdata = 32'hFFFF_FFFD;
    #1;
    checks++; if (mem_adr !== 32'h26) begin errors++; $display("FAIL prio_adr got %h want 26", mem_adr); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL prio_we got %b want 1", mem_we); end
    checks++; if (mem_wdata !== 32'hFFFF_FFFD) begin errors++; $display("FAIL prio_wdata got %h want fffffffd", mem_wdata); end
    checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL prio_pending got %b want 0", ext_ready); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL prio_stall got %b want 0", cpu_stall); end
    @(negedge clk); cpu_mem_en = 1'b0; cpu_we = 1'b0; #1;
    checks++; if (mem_adr !== 32'h03) begin errors++; $display("FAIL prio_svc_adr got %h want 3", mem_adr); end
    checks++; if (mem_wdata !== 32'h77) begin errors++; $display("FAIL prio_svc_wdata got %h want 77", mem_wdata); end
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL prio_svc_ack got %b want 0", ext_ack); end
    @(negedge clk); #1;
    checks++; if (ext_ack !== 1'b1) begin errors++; $display("FAIL prio_ack got %b want 1", ext_ack); end
    checks++; if (mem[6'h26] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL prio_mem got %h want fffffffd", mem[6'h26]); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b1; ext_adr = 32'h05; ext_wdata = 32'h1234;
    cpu_mem_en = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
    #1;
    checks++; if (cpu_rdata !== 32'hA000_0010) begin errors++; $display("FAIL starve_load got %h want a0000010", cpu_rdata); end
    @(negedge clk); ext_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL starve_wait%0d_stall got %b want 0", i, cpu_stall); end
      checks++; if (mem_adr !== 32'h10) begin errors++; $display("FAIL starve_wait%0d_adr got %h want 10", i, mem_adr); end
    end
    @(negedge clk); #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL steal_stall got %b want 1", cpu_stall); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL steal_we got %b want 1", mem_we); end
    checks++; if (mem_adr !== 32'h05) begin errors++; $display("FAIL steal_adr got %h want 5", mem_adr); end
    checks++; if (mem_wdata !== 32'h1234) begin errors++; $display("FAIL steal_wdata got %h want 1234", mem_wdata); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL steal_cpu_rdata got %h want 0", cpu_rdata); end
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL steal_run got %b want 1", cpu_run); end
    @(negedge clk); #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL steal_after_stall got %b want 0", cpu_stall); end
    checks++; if (ext_ack !== 1'b1) begin errors++; $display("FAIL steal_ack got %b want 1", ext_ack); end
    checks++; if (mem_adr !== 32'h10) begin errors++; $display("FAIL steal_after_adr got %h want 10", mem_adr); end
    @(negedge clk); cpu_mem_en = 1'b0; #1;
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL steal_ack_pulse got %b want 0", ext_ack); end
  endtask

  task automatic test_boot_done_drop();
    @(negedge clk); boot_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL bdrop%0d_run got %b want 1", i, cpu_run); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL bdrop%0d_stall got %b want 0", i, cpu_stall); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ext_req = 1'b1; ext_we = 1'b0; ext_adr = 32'h21; cpu_mem_en = 1'b1; cpu_we = 1'b0;
    @(negedge clk); ext_req = 1'b0; #1;
    checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL rmid_pending got %b want 0", ext_ready); end
    #1 reset = 1'b0;
    #1;
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", ext_ready); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rmid_stall got %b want 1", cpu_stall); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL rmid_run got %b want 0", cpu_run); end
    checks++; if (mem_adr !== 32'h0) begin errors++; $display("FAIL rmid_adr got %h want 0", mem_adr); end
    @(negedge clk); reset = 1'b1; cpu_mem_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL rmid%0d_ack got %b want 0", i, ext_ack); end
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rmid%0d_stall got %b want 1", i, cpu_stall); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid%0d_we got %b want 0", i, mem_we); end
    end
  endtask

  initial begin
    test_reset();
    test_boot_preload();
    test_boot_drain();
    test_idle_slot();
    test_cpu_priority();
    test_starvation();
    test_boot_done_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
